// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - memory-side responder: word RAM plus display register with wait states
module cpu_mem_responder #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] MEM_BASE    = '0,
  parameter int                MEM_DEPTH   = 16384,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] IO_ADDR     = 24'hFFFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              data_ready,
  output logic              busy,
  output logic              addr_err,
  output logic [DATA_W-1:0] display_value
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  // One extra bit so the end of the RAM window can be compared without wrap
  localparam logic [ADDR_W:0] MEM_END = {1'b0, MEM_BASE} + (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(1) << ADDR_W;

  // Reject configurations the decoder cannot represent
  generate
    if (MEM_END > ADDR_LIMIT) begin : g_bad_range
      $error("cpu_mem_responder: MEM_BASE+MEM_DEPTH exceeds the address space");
    end
    if ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("cpu_mem_responder: MEM_DEPTH must be a power of two");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
      $error("cpu_mem_responder: WAIT_STATES must be 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              io_hit;
  logic              ram_hit;
  logic [IDX_W-1:0]  ram_idx;
  logic              access;
  logic              ram_we;

  // Decode the latched address; the display register shadows any RAM overlap
  always_comb begin
    io_hit  = (lat_addr == IO_ADDR);
    ram_hit = !io_hit
              && ({1'b0, lat_addr} >= {1'b0, MEM_BASE})
              && ({1'b0, lat_addr} <  MEM_END);
    ram_idx = IDX_W'(lat_addr - MEM_BASE);
    access  = (state == S_WAIT) && (cnt == 4'd0);
    ram_we  = access && lat_we && ram_hit;
  end

  // RAM array has no reset; a reset during WAIT forces IDLE, so ram_we drops and nothing commits
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= lat_wdata;
    end
  end

  // Request FSM with registered handshake, read data and display register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      busy          <= 1'b0;
      data_ready    <= 1'b0;
      addr_err      <= 1'b0;
      rdata         <= '0;
      display_value <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            cnt       <= 4'(WAIT_STATES);
            busy      <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            data_ready <= 1'b1;
            state      <= S_RESP;
            if (lat_we) begin
              if (io_hit) begin
                display_value <= lat_wdata;
              end else if (!ram_hit) begin
                addr_err <= 1'b1;
              end
            end else begin
              if (io_hit) begin
                rdata <= display_value;
              end else if (ram_hit) begin
                rdata <= mem[ram_idx];
              end else begin
                rdata    <= '0;
                addr_err <= 1'b1;
              end
            end
          end
        end
        S_RESP: begin
          data_ready <= 1'b0;
          addr_err   <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - bench for cpu_mem_responder at WAIT_STATES 0, 1 and 2
module tb_cpu_mem_responder;

  localparam int NI = 3;
  localparam logic [23:0] IO = 24'hFFFF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        req [NI];
  logic        we [NI];
  logic [23:0] addr [NI];
  logic [15:0] wdata [NI];
  logic [15:0] rdata [NI];
  logic [15:0] dval [NI];
  logic        data_ready [NI];
  logic        busy [NI];
  logic        addr_err [NI];

  int ws_of [NI] = '{0, 1, 2};
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0 uses an offset RAM window 4096..20479 to exercise the base arithmetic
  cpu_mem_responder #(.MEM_BASE(24'd4096), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .data_ready(data_ready[0]), .busy(busy[0]), .addr_err(addr_err[0]),
    .display_value(dval[0]));
  cpu_mem_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .data_ready(data_ready[1]), .busy(busy[1]), .addr_err(addr_err[1]),
    .display_value(dval[1]));
  cpu_mem_responder #(.WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
    .rdata(rdata[2]), .data_ready(data_ready[2]), .busy(busy[2]), .addr_err(addr_err[2]),
    .display_value(dval[2]));

  typedef struct {
    int          k;
    bit          w;
    logic [23:0] a;
    logic [15:0] d;
    logic [15:0] er;
    bit          ee;
    bit          cr;
  } vec_t;

  typedef struct {
    logic [15:0] rd;
    bit          err;
    bit          cr;
    int          lat;
  } exp_t;

  vec_t vt [$];
  exp_t sb [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check({tag, " data_ready"}, 32'(data_ready[k]), 32'd0);
    check({tag, " busy"}, 32'(busy[k]), 32'd0);
    check({tag, " addr_err"}, 32'(addr_err[k]), 32'd0);
    check({tag, " rdata"}, 32'(rdata[k]), 32'd0);
    check({tag, " display_value"}, 32'(dval[k]), 32'd0);
  endtask

  task automatic run_txn(input int k, input bit w, input logic [23:0] a, input logic [15:0] d,
                         input logic [15:0] er, input bit ee, input bit cr);
    exp_t e;
    int   edges;
    bit   seen;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    sb.push_back('{er, ee, cr, ws_of[k] + 1});
    @(posedge clk);
    // Scramble inputs after the accept edge; they must not influence the transaction
    @(negedge clk);
    req[k] = 1'b0; we[k] = ~w; addr[k] = a ^ 24'h5; wdata[k] = ~d;
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (data_ready[k]) seen = 1'b1;
    end
    e = sb.pop_front();
    check($sformatf("ready seen k%0d a%0d", k, a), 32'(seen), 32'd1);
    if (seen) begin
      check($sformatf("latency k%0d a%0d", k, a), 32'(edges), 32'(e.lat));
      check($sformatf("addr_err k%0d a%0d", k, a), 32'(addr_err[k]), 32'(e.err));
      check($sformatf("busy in RESP k%0d", k), 32'(busy[k]), 32'd1);
      if (e.cr) check($sformatf("rdata k%0d a%0d", k, a), 32'(rdata[k]), 32'(e.rd));
      @(negedge clk);
      check($sformatf("ready one cycle k%0d", k), 32'(data_ready[k]), 32'd0);
      check($sformatf("busy after RESP k%0d", k), 32'(busy[k]), 32'd0);
      check($sformatf("addr_err clear k%0d", k), 32'(addr_err[k]), 32'd0);
    end
  endtask

  initial begin
    int acc [$];
    bit pb;
    int pulses;
    int rises;
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end

    // Reset applied asynchronously, outputs checked before any clock edge
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) check_idle_outputs(k, "por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // {k, write, addr, wdata, expected rdata, expected addr_err, check rdata}
    vt.push_back('{1, 1'b1, 24'd9216,  16'hA5A5, 16'h0000, 1'b0, 1'b0});
    vt.push_back('{1, 1'b0, 24'd9216,  16'h0000, 16'hA5A5, 1'b0, 1'b1});
    vt.push_back('{0, 1'b1, 24'd20479, 16'h1234, 16'h0000, 1'b0, 1'b0});
    vt.push_back('{0, 1'b0, 24'd20479, 16'h0000, 16'h1234, 1'b0, 1'b1});
    vt.push_back('{0, 1'b0, 24'd20480, 16'h0000, 16'h0000, 1'b1, 1'b1});
    vt.push_back('{0, 1'b1, 24'd4096,  16'h5A5A, 16'h0000, 1'b0, 1'b0});
    vt.push_back('{0, 1'b0, 24'd4095,  16'h0000, 16'h0000, 1'b1, 1'b1});
    vt.push_back('{0, 1'b0, 24'd4096,  16'h0000, 16'h5A5A, 1'b0, 1'b1});
    vt.push_back('{0, 1'b1, 24'd20480, 16'hDEAD, 16'h0000, 1'b1, 1'b0});
    vt.push_back('{0, 1'b0, 24'd4096,  16'h0000, 16'h5A5A, 1'b0, 1'b1});
    vt.push_back('{1, 1'b1, 24'd16128, 16'h1111, 16'h0000, 1'b0, 1'b0});
    vt.push_back('{1, 1'b1, IO,        16'h00F3, 16'h0000, 1'b0, 1'b0});
    vt.push_back('{1, 1'b0, IO,        16'h0000, 16'h00F3, 1'b0, 1'b1});
    vt.push_back('{1, 1'b0, 24'd16128, 16'h0000, 16'h1111, 1'b0, 1'b1});
    vt.push_back('{1, 1'b0, 24'd9216,  16'h0000, 16'hA5A5, 1'b0, 1'b1});
    vt.push_back('{2, 1'b1, 24'd100,   16'hBEEF, 16'h0000, 1'b0, 1'b0});
    vt.push_back('{2, 1'b0, 24'd100,   16'h0000, 16'hBEEF, 1'b0, 1'b1});

    foreach (vt[i]) run_txn(vt[i].k, vt[i].w, vt[i].a, vt[i].d, vt[i].er, vt[i].ee, vt[i].cr);

    check("display_value ws1", 32'(dval[1]), 32'h00F3);
    check("display_value ws0 untouched", 32'(dval[0]), 32'h0000);

    // req held high: accepts must be WAIT_STATES+3 = 5 cycles apart
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 24'd100;
    pb = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (busy[2] && !pb) acc.push_back(cyc);
      if (data_ready[2]) check("held req rdata", 32'(rdata[2]), 32'h0000BEEF);
      pb = busy[2];
    end
    req[2] = 1'b0;
    check("held req accept count", 32'(acc.size() >= 4), 32'd1);
    for (int i = 1; i < 4 && i < acc.size(); i++)
      check($sformatf("held req spacing %0d", i), 32'(acc[i] - acc[i-1]), 32'd5);
    for (int i = 0; i < 10 && busy[2]; i++) @(negedge clk);
    check("idle after held req", 32'(busy[2]), 32'd0);

    // Pulsing req during WAIT and RESP must not start another transaction
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 24'd100;
    pulses = 0;
    rises = 0;
    pb = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (data_ready[2]) pulses++;
      if (busy[2] && !pb) rises++;
      pb = busy[2];
      req[2] = (j == 1 || j == 3);
    end
    check("pulsed req responses", 32'(pulses), 32'd1);
    check("pulsed req accepts", 32'(rises), 32'd1);
    check("pulsed req idle", 32'(busy[2]), 32'd0);

    // Reset during WAIT of a write: no response, write never commits
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 24'd100; wdata[2] = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    check("busy in WAIT", 32'(busy[2]), 32'd1);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) check_idle_outputs(k, $sformatf("async rst k%0d", k));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (data_ready[2] || busy[2]) pulses++;
    end
    check("no activity after reset", 32'(pulses), 32'd0);
    run_txn(2, 1'b0, 24'd100, 16'h0000, 16'hBEEF, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the 16-bit core's data/instruction bus.
- Accepts one read or write request at a time on the 24-bit word address bus and services it from an internal synchronous word RAM or a memory-mapped display register.
- Returns a one-cycle data_ready pulse after a programmable number of wait states, so the core's Fetch/Memory states can stall on it.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 24, word address width.
- MEM_BASE, 24'd0, first word address decoded to the RAM.
- MEM_DEPTH, 16384, number of RAM words; must be a power of two and cover PC start 9216.
- WAIT_STATES, 1, extra cycles inserted before the access edge, range 0..15.
- IO_ADDR, 24'hFFFF00, word address of the display register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  24  word address; sampled with req.
- wdata  in  16  write data; sampled with req.
- rdata  out  16  read data; valid while data_ready = 1, held until the next response.
- data_ready  out  1  one-cycle completion pulse, for both reads and writes.
- busy  out  1  high from the accept edge until the edge that leaves RESP.
- addr_err  out  1  pulses with data_ready when the address decodes to neither RAM nor IO.
- display_value  out  16  last value written to IO_ADDR; drives the seven-segment mux.

Behaviour:
- Reset (async, active-high):
  - state = IDLE, busy = 0, data_ready = 0, addr_err = 0, rdata = 0, display_value = 0, wait counter = 0.
  - Latched request is discarded and a pending write is never committed.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req = 1 at a rising edge: latch addr, we and wdata; load counter = WAIT_STATES; go to WAIT; busy <= 1.
  - Otherwise remain in IDLE.
- WAIT:
  - If counter != 0: decrement and stay.
  - If counter == 0: perform the access at this edge, set data_ready <= 1, go to RESP.
- RESP:
  - data_ready = 1 for exactly this one cycle.
  - Next edge: data_ready <= 0, addr_err <= 0, busy <= 0, go to IDLE.
- Latency and throughput:
  - data_ready rises WAIT_STATES+1 edges after the accept edge.
  - Minimum request spacing is WAIT_STATES+3 cycles.
- req handling:
  - req is ignored in WAIT and RESP; no queueing.
  - A req held high through RESP is accepted on the first edge in IDLE.
  - Inputs are sampled only at the accept edge; later changes have no effect on the transaction.
- Address decode, using the latched address:
  - RAM hit: MEM_BASE <= addr < MEM_BASE+MEM_DEPTH; RAM index = addr - MEM_BASE, low log2(MEM_DEPTH) bits.
  - IO hit: addr == IO_ADDR, checked before the RAM range.
  - Miss: anything else.
- Read:
  - RAM or IO: rdata <= stored word / display_value.
  - Miss: rdata <= 0 and addr_err <= 1.
- Write:
  - RAM: word written at the access edge.
  - IO: display_value updated at the access edge.
  - Miss: no state change, addr_err <= 1; rdata is left unchanged.
- Read-after-write to the same address in the next transaction returns the new data.
- Address arithmetic is unsigned, 24-bit, with no wrap.
- MEM_BASE+MEM_DEPTH overflowing 24 bits is illegal configuration and must be flagged at elaboration.

Test Plan:
- Reset asserted asynchronously mid-cycle -> all outputs 0 immediately, state IDLE, no clock needed.
- WAIT_STATES=1: write addr 9216 data 16'hA5A5, then read 9216 -> each data_ready rises exactly 2 edges after its accept edge; read rdata = 16'hA5A5; addr_err = 0.
- WAIT_STATES=0: read MEM_BASE+MEM_DEPTH-1 after writing 16'h1234, then read MEM_BASE+MEM_DEPTH -> first rdata = 16'h1234; second rdata = 0 with addr_err = 1 in the same cycle as data_ready.
- Write 16'h00F3 to IO_ADDR -> display_value = 16'h00F3 from the access edge onward; read IO_ADDR returns 16'h00F3; RAM location IO_ADDR-MEM_BASE unaffected.
- req held high continuously with WAIT_STATES=2 -> accepts spaced exactly 5 cycles; pulsing req during WAIT/RESP starts no extra transaction.
- Write 16'hBEEF to 100, then write 16'h0000 to 100 with reset asserted during WAIT -> no data_ready pulse; a post-reset read of 100 returns 16'hBEEF.
